// File: rtl/sna_pkg.sv
// Shared definitions for the slave network adapter response path.
// Holds the flit type codes, the packetizer state encoding and the bit
// positions of the fields inside the HEAD flit payload.
package sna_pkg;

    // Flit type codes carried in the top two bits of every flit.
    localparam logic [1:0] FLIT_HEAD = 2'b01;
    localparam logic [1:0] FLIT_TAIL = 2'b10;

    // HEAD payload layout: [DATA_W-1:4] route header, [3] kind, [2] zero, [1:0] resp.
    localparam int unsigned HEAD_HDR_LSB  = 4;
    localparam int unsigned HEAD_KIND_BIT = 3;
    localparam int unsigned HEAD_RESP_LSB = 0;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StHead = 2'b01,
        StTail = 2'b10
    } sna_state_e;

endpackage

// File: rtl/sna_vc_select.sv
// Lowest-index one-hot priority encoder used to pick a free virtual channel.
// Ports:
//   req    - per-VC request/free flags
//   onehot - one-hot of the lowest set bit of req (zero when req is zero)
//   any    - high when any bit of req is set
module sna_vc_select #(
    parameter int unsigned NUM_VC = 8
) (
    input  logic [NUM_VC-1:0] req,
    output logic [NUM_VC-1:0] onehot,
    output logic              any
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        onehot = '0;
        for (int i = int'(NUM_VC) - 1; i >= 0; i--) begin
            if (req[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/sna_response_packetizer.sv
// Response-path packetizer for the slave network adapter. Accepts AXI4-Lite
// R and B responses, arbitrates round-robin between them, claims the
// lowest-index free VC and emits a HEAD/TAIL packet under per-VC on/off
// flow control.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   route_hdr                - route header for the response being accepted
//   rvalid/rdata/rresp/rready - AXI R channel
//   bvalid/bresp/bready      - AXI B channel
//   is_allocatable           - per-VC free flags
//   is_on_off                - per-VC downstream on flags
//   vc_claim                 - one-hot VC claim, pulses in the accept cycle
//   vc_sel                   - one-hot VC of the packet in flight
//   noc_data, is_valid       - registered flit and its valid strobe
module sna_response_packetizer
    import sna_pkg::*;
#(
    parameter int unsigned NUM_VC = 8,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned FLIT_W = DATA_W + 2,
    parameter int unsigned HDR_W  = DATA_W - 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [HDR_W-1:0]  route_hdr,
    input  logic              rvalid,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    output logic              rready,
    input  logic              bvalid,
    input  logic [1:0]        bresp,
    output logic              bready,
    input  logic [NUM_VC-1:0] is_allocatable,
    input  logic [NUM_VC-1:0] is_on_off,
    output logic [NUM_VC-1:0] vc_claim,
    output logic [NUM_VC-1:0] vc_sel,
    output logic [FLIT_W-1:0] noc_data,
    output logic              is_valid
);

    sna_state_e        state_q;
    logic              rr_q;      // 0: R wins a collision, 1: B wins
    logic [HDR_W-1:0]  hdr_q;
    logic              kind_q;    // 1 read, 0 write
    logic [1:0]        resp_q;
    logic [DATA_W-1:0] data_q;
    logic [NUM_VC-1:0] vc_sel_q;
    logic [FLIT_W-1:0] noc_data_q;
    logic              is_valid_q;

    logic [NUM_VC-1:0] free_onehot;
    logic              free_any;
    logic              can_grant;
    logic              grant_r;
    logic              grant_b;
    logic              vc_on;

    sna_vc_select #(
        .NUM_VC (NUM_VC)
    ) u_vc_select (
        .req    (is_allocatable),
        .onehot (free_onehot),
        .any    (free_any)
    );

    // Reset overrides the handshake so nothing is accepted in a reset cycle.
    assign can_grant = !rst && (state_q == StIdle) && free_any;
    assign grant_r   = can_grant && rvalid && (!bvalid || !rr_q);
    assign grant_b   = can_grant && bvalid && (!rvalid || rr_q);
    assign vc_on     = |(is_on_off & vc_sel_q);

    assign rready   = grant_r;
    assign bready   = grant_b;
    assign vc_claim = (grant_r || grant_b) ? free_onehot : '0;
    assign vc_sel   = vc_sel_q;
    assign noc_data = noc_data_q;
    assign is_valid = is_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            rr_q       <= 1'b0;
            hdr_q      <= '0;
            kind_q     <= 1'b0;
            resp_q     <= 2'b00;
            data_q     <= '0;
            vc_sel_q   <= '0;
            noc_data_q <= '0;
            is_valid_q <= 1'b0;
        end else begin
            is_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (grant_r || grant_b) begin
                        hdr_q    <= route_hdr;
                        kind_q   <= grant_r;
                        resp_q   <= grant_r ? rresp : bresp;
                        data_q   <= grant_r ? rdata : '0;
                        vc_sel_q <= free_onehot;
                        rr_q     <= grant_r;  // next collision favours the loser
                        state_q  <= StHead;
                    end
                end
                StHead: begin
                    if (vc_on) begin
                        noc_data_q <= {FLIT_HEAD, hdr_q, kind_q, 1'b0, resp_q};
                        is_valid_q <= 1'b1;
                        state_q    <= StTail;
                    end
                end
                StTail: begin
                    if (vc_on) begin
                        noc_data_q <= {FLIT_TAIL, data_q};
                        is_valid_q <= 1'b1;
                        vc_sel_q   <= '0;
                        state_q    <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sna_response_packetizer.sv
module tb_sna_response_packetizer;

    logic        clk = 1'b0;
    logic        rst;
    logic [27:0] route_hdr;
    logic        rvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rready;
    logic        bvalid;
    logic [1:0]  bresp;
    logic        bready;
    logic [7:0]  is_allocatable;
    logic [7:0]  is_on_off;
    logic [7:0]  vc_claim;
    logic [7:0]  vc_sel;
    logic [33:0] noc_data;
    logic        is_valid;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sna_response_packetizer #(
        .NUM_VC (8),
        .DATA_W (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .route_hdr      (route_hdr),
        .rvalid         (rvalid),
        .rdata          (rdata),
        .rresp          (rresp),
        .rready         (rready),
        .bvalid         (bvalid),
        .bresp          (bresp),
        .bready         (bready),
        .is_allocatable (is_allocatable),
        .is_on_off      (is_on_off),
        .vc_claim       (vc_claim),
        .vc_sel         (vc_sel),
        .noc_data       (noc_data),
        .is_valid       (is_valid)
    );

    typedef struct {
        logic        is_read;
        logic [31:0] rd;
        logic [1:0]  resp;
        logic [27:0] hdr;
        logic [7:0]  alloc;
        logic [7:0]  claim;
        logic [33:0] head;
        logic [33:0] tail;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        rvalid         = v.is_read;
        bvalid         = !v.is_read;
        rdata          = v.rd;
        rresp          = v.is_read ? v.resp : 2'b00;
        bresp          = v.is_read ? 2'b00 : v.resp;
        route_hdr      = v.hdr;
        is_allocatable = v.alloc;
        is_on_off      = 8'hFF;
        #1;
        chk($sformatf("v%0d_rready", idx), 64'(rready), 64'(v.is_read));
        chk($sformatf("v%0d_bready", idx), 64'(bready), 64'(!v.is_read));
        chk($sformatf("v%0d_vc_claim", idx), 64'(vc_claim), 64'(v.claim));
        step();
        // Scramble inputs to show the packet uses captured values.
        rvalid         = 1'b0;
        bvalid         = 1'b0;
        rdata          = 32'hCAFEF00D;
        route_hdr      = '0;
        is_allocatable = 8'h00;
        #1;
        chk($sformatf("v%0d_claim_pulse", idx), 64'(vc_claim), 64'h0);
        chk($sformatf("v%0d_wait_valid", idx), 64'(is_valid), 64'h0);
        chk($sformatf("v%0d_vc_sel", idx), 64'(vc_sel), 64'(v.claim));
        step();
        chk($sformatf("v%0d_head_valid", idx), 64'(is_valid), 64'h1);
        chk($sformatf("v%0d_head", idx), 64'(noc_data), 64'(v.head));
        step();
        chk($sformatf("v%0d_tail_valid", idx), 64'(is_valid), 64'h1);
        chk($sformatf("v%0d_tail", idx), 64'(noc_data), 64'(v.tail));
        step();
        chk($sformatf("v%0d_after_valid", idx), 64'(is_valid), 64'h0);
        chk($sformatf("v%0d_hold", idx), 64'(noc_data), 64'(v.tail));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rready"}, 64'(rready), 64'h0);
        chk({tag, "_bready"}, 64'(bready), 64'h0);
        chk({tag, "_vc_claim"}, 64'(vc_claim), 64'h0);
        chk({tag, "_vc_sel"}, 64'(vc_sel), 64'h0);
        chk({tag, "_noc_data"}, 64'(noc_data), 64'h0);
        chk({tag, "_is_valid"}, 64'(is_valid), 64'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{1'b1, 32'hDEADBEEF, 2'b00, 28'h0ABCDEF, 8'h04, 8'h04,
                    {2'b01, 28'h0ABCDEF, 4'b1000}, {2'b10, 32'hDEADBEEF}};
        vecs[1] = '{1'b0, 32'h13572468, 2'b10, 28'h0000123, 8'h30, 8'h10,
                    {2'b01, 28'h0000123, 4'b0010}, {2'b10, 32'h00000000}};
        vecs[2] = '{1'b1, 32'h12345678, 2'b11, 28'hFFFFFFF, 8'hFF, 8'h01,
                    {2'b01, 28'hFFFFFFF, 4'b1011}, {2'b10, 32'h12345678}};
        vecs[3] = '{1'b0, 32'hA5A5A5A5, 2'b01, 28'h5555555, 8'h80, 8'h80,
                    {2'b01, 28'h5555555, 4'b0001}, {2'b10, 32'h00000000}};

        rvalid         = 1'b0;
        bvalid         = 1'b0;
        rdata          = '0;
        rresp          = 2'b00;
        bresp          = 2'b00;
        route_hdr      = '0;
        is_allocatable = 8'h00;
        is_on_off      = 8'hFF;
        do_reset();
        check_reset_outputs("reset");

        for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

        // Collisions from reset: R, B, R, B.
        do_reset();
        rvalid         = 1'b1;
        bvalid         = 1'b1;
        rdata          = 32'h0000BEEF;
        rresp          = 2'b00;
        bresp          = 2'b00;
        route_hdr      = 28'h0000042;
        is_allocatable = 8'h01;
        is_on_off      = 8'hFF;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("coll%0d_rready", k), 64'(rready), 64'((k % 2) == 0));
            chk($sformatf("coll%0d_bready", k), 64'(bready), 64'((k % 2) == 1));
            step();
            chk($sformatf("coll%0d_busy_ready", k), 64'({rready, bready}), 64'h0);
            step();
            chk($sformatf("coll%0d_kind", k), 64'(noc_data[3]), 64'((k % 2) == 0));
            step();
        end
        rvalid = 1'b0;
        bvalid = 1'b0;
        step();

        // Back-pressure on the captured VC only: TAIL delayed exactly 4 cycles.
        rvalid         = 1'b1;
        rdata          = 32'h0BADF00D;
        route_hdr      = 28'h0000777;
        is_allocatable = 8'h01;
        #1;
        chk("bp_claim", 64'(vc_claim), 64'h01);
        step();
        rvalid = 1'b0;
        step();
        chk("bp_head_valid", 64'(is_valid), 64'h1);
        chk("bp_head", 64'(noc_data), 64'({2'b01, 28'h0000777, 4'b1000}));
        is_on_off = 8'hFE;
        for (int c = 0; c < 4; c++) begin
            step();
            chk($sformatf("bp_stall%0d_valid", c), 64'(is_valid), 64'h0);
            chk($sformatf("bp_stall%0d_hold", c), 64'(noc_data),
                64'({2'b01, 28'h0000777, 4'b1000}));
        end
        is_on_off = 8'hFF;
        step();
        chk("bp_tail_valid", 64'(is_valid), 64'h1);
        chk("bp_tail", 64'(noc_data), 64'({2'b10, 32'h0BADF00D}));
        step();

        // No free VC: R must wait; then VC 7 frees up.
        rvalid         = 1'b1;
        rdata          = 32'h00000077;
        is_allocatable = 8'h00;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("noalloc%0d_rready", c), 64'(rready), 64'h0);
            step();
            chk($sformatf("noalloc%0d_valid", c), 64'(is_valid), 64'h0);
        end
        is_allocatable = 8'h80;
        #1;
        chk("alloc80_rready", 64'(rready), 64'h1);
        chk("alloc80_claim", 64'(vc_claim), 64'h80);
        step();
        rvalid = 1'b0;
        chk("alloc80_vc_sel", 64'(vc_sel), 64'h80);
        step();
        chk("alloc80_head_valid", 64'(is_valid), 64'h1);
        step();
        chk("alloc80_tail", 64'(noc_data), 64'({2'b10, 32'h00000077}));
        step();

        // Reset while in TAIL: no TAIL flit, outputs cleared, then normal read.
        rvalid         = 1'b1;
        rdata          = 32'h11111111;
        is_allocatable = 8'h02;
        step();
        rvalid = 1'b0;
        step();
        chk("rst_head_valid", 64'(is_valid), 64'h1);
        rst            = 1'b1;
        rvalid         = 1'b1;
        is_allocatable = 8'hFF;
        #1;
        chk("rst_priority_rready", 64'(rready), 64'h0);
        chk("rst_priority_claim", 64'(vc_claim), 64'h0);
        step();
        rst    = 1'b0;
        rvalid = 1'b0;
        #1;
        check_reset_outputs("rst_tail");
        step();
        chk("rst_no_tail", 64'(is_valid), 64'h0);
        run_vec(vecs[0], 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
